cordic_angle_reduce: RTL

Upstream range-reduction stage for the CORDIC rotator. It pops raw angles from the input FIFO (first-word-fall-through read side) and wraps them into [-π, π]. It then folds them into the CORDIC convergence range [-π/2, π/2] and hands a Q2.29 angle plus a negate flag to the CORDIC core over a valid/ready handshake. The downstream quadrant fix-up uses the negate flag to sign-correct cos/sin.

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/cordic_angle_reduce.sv | 111 +++++++++++
 2 files changed

// File: rtl/cordic_pkg.sv
// Shared Q-format widths, angle constants, FSM state type and fold helper
// for the CORDIC angle range-reduction stage.
package cordic_pkg;

    localparam int IN_FRAC_W  = 24;
    localparam int OUT_FRAC_W = 29;

    // Q7.24 constants, round-to-nearest
    localparam logic signed [31:0] PI      = 32'sh03243F6B;
    localparam logic signed [31:0] TWO_PI  = 32'sh06487ED5;
    localparam logic signed [31:0] HALF_PI = 32'sh01921FB5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WRAP = 2'd1,
        FOLD = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Fold [-pi, pi] into [-pi/2, pi/2]; returns {negate, theta}
    function automatic logic [32:0] fold_angle(input logic signed [31:0] theta);
        logic [32:0] res;
        if (theta > HALF_PI) begin
            res = {1'b1, theta - PI};
        end else if (theta < -HALF_PI) begin
            res = {1'b1, theta + PI};
        end else begin
            res = {1'b0, theta};
        end
        return res;
    endfunction

endpackage

// File: rtl/cordic_angle_reduce.sv
// Range reduction ahead of the CORDIC rotator: wrap to [-pi, pi], fold to [-pi/2, pi/2].
// Define CORDIC_ANGLE_WRAP_EN to include the multi-cycle WRAP state (full +/-128 rad input).
module cordic_angle_reduce
    import cordic_pkg::*;
#(
    parameter int IN_FRAC  = IN_FRAC_W,
    parameter int OUT_FRAC = OUT_FRAC_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_empty,
    output logic        in_rd_en,
    input  logic [31:0] in_dout,
    output logic [31:0] theta_out,
    output logic        negate_out,
    output logic        out_valid,
    input  logic        out_ready
);

`ifdef CORDIC_ANGLE_WRAP_EN
    localparam state_t POP_NEXT = WRAP;
`else
    localparam state_t POP_NEXT = FOLD;
`endif

    state_t             state_q, state_d;
    logic signed [31:0] theta_q, theta_d;
    logic               negate_q, negate_d;
    logic               xfer_s, pop_s;

    // Handshake decode; the pop is masked while reset is held
    always_comb begin
        xfer_s = (state_q == OUT) && out_ready;
        pop_s  = !reset && !in_empty && ((state_q == IDLE) || xfer_s);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pop_s) state_d = POP_NEXT;
                else       state_d = IDLE;
            end
`ifdef CORDIC_ANGLE_WRAP_EN
            WRAP: begin
                if ((theta_q > PI) || (theta_q < -PI)) state_d = WRAP;
                else                                   state_d = FOLD;
            end
`endif
            FOLD: state_d = OUT;
            OUT: begin
                if (pop_s)       state_d = POP_NEXT;
                else if (xfer_s) state_d = IDLE;
                else             state_d = OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Angle register and negate flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            theta_q  <= 32'sd0;
            negate_q <= 1'b0;
        end else begin
            theta_q  <= theta_d;
            negate_q <= negate_d;
        end
    end

    // Datapath: capture on pop, one wrap correction per WRAP cycle, single fold
    always_comb begin
        theta_d  = theta_q;
        negate_d = negate_q;
        if (pop_s) begin
            theta_d  = $signed(in_dout);
            negate_d = 1'b0;
        end else begin
            case (state_q)
`ifdef CORDIC_ANGLE_WRAP_EN
                WRAP: begin
                    if (theta_q > PI)       theta_d = theta_q - TWO_PI;
                    else if (theta_q < -PI) theta_d = theta_q + TWO_PI;
                    else                    theta_d = theta_q;
                end
`endif
                FOLD:    {negate_d, theta_d} = fold_angle(theta_q);
                default: theta_d = theta_q;
            endcase
        end
    end

    // Outputs; theta_out is the held register rescaled to Q2.29
    always_comb begin
        in_rd_en   = pop_s;
        out_valid  = (state_q == OUT);
        theta_out  = theta_q <<< (OUT_FRAC - IN_FRAC);
        negate_out = negate_q;
    end

endmodule
